if_id_stage: RTL and testbench

//  Instruction-fetch stage between the PC register and the ID stage. Each fetch

---
 rtl/if_id_stage_if.sv | 22 ++
 rtl/if_id_stage.sv | 147 ++++++++++++++
 tb/tb_if_id_stage.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/if_id_stage_if.sv
// Instruction-memory fetch bus: one-cycle request strobe with address, response strobe with data.
// The fetch stage drives the master side; the instruction memory drives the slave side.
interface if_id_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/if_id_stage.sv
// Fetch stage: PC -> imem request -> IF/ID register, one-entry skid buffer; IF_PERF_CNT_EN adds a stall counter.
// Latency: request in IDLE, word lands in IF/ID on the edge ending the response cycle (1 instr / 2 cycles).
// Backpressure: id_shouldStall parks the word in the skid buffer; if_busy holds the PC outside delivery cycles.
module if_id_stage #(
  parameter logic [31:0] NOP_INST        = 32'h0000_0000,
  parameter bit          FLUSH_ON_BRANCH = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_en,
  input  logic          id_shouldStall,
  input  logic          id_shouldJumpOrBranch,
  input  logic [31:0]   if_pc,
  if_id_stage_if.master imem,
  output logic [31:0]   id_pc,
  output logic [31:0]   id_inst,
  output logic          id_valid,
`ifdef IF_PERF_CNT_EN
  output logic [31:0]   fetch_stall_cycles,
`endif
  output logic          if_busy
);

  typedef enum logic [1:0] {IDLE, WAIT, FULL} state_e;

  state_e      state_q, state_d;
  logic        kill_q, kill_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic [31:0] buf_inst_q, buf_inst_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_inst_q, id_inst_d;
  logic        id_valid_q, id_valid_d;
  logic        branch;
  logic        req;
  logic        req_out;
  logic        busy;

  assign branch = id_shouldJumpOrBranch & cpu_en;

  always_comb begin
    state_d    = state_q;
    kill_d     = kill_q;
    req_pc_d   = req_pc_q;
    buf_pc_d   = buf_pc_q;
    buf_inst_d = buf_inst_q;
    id_pc_d    = id_pc_q;
    id_inst_d  = id_inst_q;
    id_valid_d = id_valid_q;
    req        = 1'b0;
    busy       = 1'b1;
    case (state_q)
      IDLE: begin
        if (cpu_en) begin
          req      = 1'b1;
          req_pc_d = if_pc;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        // The response is captured even while frozen; only delivery needs cpu_en.
        if (imem.imem_rvalid) begin
          if (kill_q || branch) begin
            kill_d  = 1'b0;
            state_d = IDLE;
          end else if (cpu_en && !id_shouldStall) begin
            id_pc_d    = req_pc_q;
            id_inst_d  = imem.imem_rdata;
            id_valid_d = 1'b1;
            busy       = 1'b0;
            state_d    = IDLE;
          end else begin
            buf_pc_d   = req_pc_q;
            buf_inst_d = imem.imem_rdata;
            state_d    = FULL;
          end
        end else if (branch) begin
          kill_d = 1'b1;
        end
      end
      FULL: begin
        if (branch) begin
          state_d = IDLE;
        end else if (cpu_en && !id_shouldStall) begin
          id_pc_d    = buf_pc_q;
          id_inst_d  = buf_inst_q;
          id_valid_d = 1'b1;
          busy       = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (branch && FLUSH_ON_BRANCH) begin
      id_inst_d  = NOP_INST;
      id_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      kill_q     <= 1'b0;
      req_pc_q   <= '0;
      buf_pc_q   <= '0;
      buf_inst_q <= '0;
      id_pc_q    <= '0;
      id_inst_q  <= NOP_INST;
      id_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      kill_q     <= kill_d;
      req_pc_q   <= req_pc_d;
      buf_pc_q   <= buf_pc_d;
      buf_inst_q <= buf_inst_d;
      id_pc_q    <= id_pc_d;
      id_inst_q  <= id_inst_d;
      id_valid_q <= id_valid_d;
    end
  end

  // The strobe is qualified by rst so nothing is issued while reset is asserted.
  assign req_out        = req & rst;
  assign imem.imem_req  = req_out;
  assign imem.imem_addr = req_out ? if_pc : 32'h0;
  assign id_pc          = id_pc_q;
  assign id_inst        = id_inst_q;
  assign id_valid       = id_valid_q;
  assign if_busy        = busy;

`ifdef IF_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (cpu_en && (state_q != IDLE) && busy) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stall_cnt_q <= '0;
    else      stall_cnt_q <= stall_cnt_d;
  end

  assign fetch_stall_cycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Bench for if_id_stage: directed scenarios then randomized traffic against a cycle-level fetch model.
module tb_if_id_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, cpu_en, id_shouldStall, id_shouldJumpOrBranch;
  logic [31:0] if_pc, id_pc, id_inst;
  logic        id_valid, if_busy;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_stall_cycles;
  logic [31:0] perf_base;
`endif

  int checks = 0;
  int failures = 0;

  if_id_stage_if bus ();

  if_id_stage #(.NOP_INST(NOP), .FLUSH_ON_BRANCH(1'b1)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .cpu_en                (cpu_en),
    .id_shouldStall        (id_shouldStall),
    .id_shouldJumpOrBranch (id_shouldJumpOrBranch),
    .if_pc                 (if_pc),
    .imem                  (bus),
    .id_pc                 (id_pc),
    .id_inst               (id_inst),
    .id_valid              (id_valid),
`ifdef IF_PERF_CNT_EN
    .fetch_stall_cycles    (fetch_stall_cycles),
`endif
    .if_busy               (if_busy)
  );

  always #5 clk = ~clk;

  // Reference model: is a fetch in flight, is it doomed, is a word parked, what IF/ID holds.
  logic        m_inflight, m_kill, m_full, m_idvld;
  logic [31:0] m_reqpc, m_bpc, m_binst, m_idpc, m_idinst, m_cnt;

  // Memory: one pending response, delivered mem_cnt cycles after the request.
  int          mem_cnt = 0;
  logic [31:0] mem_dat = 0;
  int          next_lat = 1;
  logic [31:0] next_rdata = 0;
  bit          spurious_en = 0;

  logic        last_req, last_busy;
  logic [31:0] last_addr, saved;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_inflight = 0; m_kill = 0; m_full = 0;
    m_idpc = 0; m_idinst = NOP; m_idvld = 0; m_cnt = 0;
  endtask

  // One clock cycle: inputs already driven by the caller at posedge+1.
  task automatic cycle();
    logic        rv, br, idle, deliver, e_req, e_busy;
    logic [31:0] rd;
    rv = (mem_cnt == 1) || (spurious_en && mem_cnt == 0 && $urandom_range(0, 7) == 0);
    rd = (mem_cnt == 1) ? mem_dat : $urandom;
    bus.imem_rvalid = rv;
    bus.imem_rdata  = rd;
    if (!rst) model_reset();
    @(negedge clk);
    idle    = !m_inflight && !m_full;
    br      = id_shouldJumpOrBranch && cpu_en;
    deliver = rst && cpu_en && !br && !id_shouldStall && ((m_inflight && rv && !m_kill) || m_full);
    e_req   = rst && cpu_en && idle;
    e_busy  = !deliver;
    check("imem_req",  {31'b0, bus.imem_req}, {31'b0, e_req});
    check("imem_addr", bus.imem_addr, e_req ? if_pc : 32'h0);
    check("if_busy",   {31'b0, if_busy}, {31'b0, e_busy});
    check("id_pc",     id_pc, m_idpc);
    check("id_inst",   id_inst, m_idinst);
    check("id_valid",  {31'b0, id_valid}, {31'b0, m_idvld});
`ifdef IF_PERF_CNT_EN
    check("stall_cnt", fetch_stall_cycles, m_cnt);
`endif
    last_req  = bus.imem_req;
    last_addr = bus.imem_addr;
    last_busy = if_busy;
    @(posedge clk);
    if (rst) begin
      if (cpu_en && !idle && e_busy) m_cnt = m_cnt + 1;
      if (idle) begin
        if (cpu_en) begin m_inflight = 1; m_reqpc = if_pc; end
      end else if (m_inflight) begin
        if (rv) begin
          m_inflight = 0;
          if (m_kill || br) m_kill = 0;
          else if (deliver) begin m_idpc = m_reqpc; m_idinst = rd; m_idvld = 1; end
          else begin m_full = 1; m_bpc = m_reqpc; m_binst = rd; end
        end else if (br) begin
          m_kill = 1;
        end
      end else begin
        if (br) m_full = 0;
        else if (deliver) begin m_idpc = m_bpc; m_idinst = m_binst; m_idvld = 1; m_full = 0; end
      end
      if (br) begin m_idinst = NOP; m_idvld = 0; end
    end
    if (mem_cnt > 0) mem_cnt--;
    if (e_req) begin mem_cnt = next_lat; mem_dat = next_rdata; end
    #1;
    bus.imem_rvalid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},   {31'b0, bus.imem_req}, 32'h0);
    check({tag, "_addr"},  bus.imem_addr, 32'h0);
    check({tag, "_pc"},    id_pc, 32'h0);
    check({tag, "_inst"},  id_inst, NOP);
    check({tag, "_valid"}, {31'b0, id_valid}, 32'h0);
    check({tag, "_busy"},  {31'b0, if_busy}, 32'h1);
  endtask

  initial begin
    rst = 1'b0; cpu_en = 1'b0; id_shouldStall = 1'b0; id_shouldJumpOrBranch = 1'b0;
    if_pc = 32'h0; bus.imem_rvalid = 1'b0; bus.imem_rdata = 32'h0;
    model_reset();
    m_reqpc = 0; m_bpc = 0; m_binst = 0;

    // Reset state, with cpu_en high to show no request escapes during reset.
    @(posedge clk); #1;
    cpu_en = 1'b1;
    #1;
    check_reset_outputs("rst");
    cycle();
    rst = 1'b1;

    // Single fetch, 1-cycle memory.
    if_pc = 32'h10; next_lat = 1; next_rdata = 32'h2402_0005;
    cycle();
    check("t1_req", {31'b0, last_req}, 32'h1);
    check("t1_addr", last_addr, 32'h10);
    cycle();
    check("t1_busy", {31'b0, last_busy}, 32'h0);
    check("t1_inst", id_inst, 32'h2402_0005);
    check("t1_pc", id_pc, 32'h10);
    check("t1_valid", {31'b0, id_valid}, 32'h1);

    // Response during a 3-cycle ID stall parks in the buffer.
    if_pc = 32'h14; next_rdata = 32'h1111_2222;
    cycle();
    id_shouldStall = 1'b1;
    repeat (3) begin
      cycle();
      check("stall_busy", {31'b0, last_busy}, 32'h1);
      check("stall_hold", id_inst, 32'h2402_0005);
    end
    id_shouldStall = 1'b0;
    cycle();
    check("drain_busy", {31'b0, last_busy}, 32'h0);
    check("drain_inst", id_inst, 32'h1111_2222);
    check("drain_pc", id_pc, 32'h14);

    // Branch while waiting: the late word is dropped and IF/ID is flushed.
    if_pc = 32'h18; next_lat = 2; next_rdata = 32'hDEAD_BEEF;
    cycle();
    id_shouldJumpOrBranch = 1'b1;
    cycle();
    id_shouldJumpOrBranch = 1'b0; if_pc = 32'h40;
    cycle();
    check("br_busy", {31'b0, last_busy}, 32'h1);
    check("br_valid", {31'b0, id_valid}, 32'h0);
    check("br_inst", id_inst, NOP);
    next_lat = 1; next_rdata = 32'h0000_1234;
    cycle();
    check("br_newreq", {31'b0, last_req}, 32'h1);
    check("br_newaddr", last_addr, 32'h40);
    cycle();
    check("br_after", id_inst, 32'h0000_1234);

    // Freeze in IDLE.
    saved = id_inst;
    cpu_en = 1'b0; if_pc = 32'h80;
    repeat (4) begin
      cycle();
      check("frz_req", {31'b0, last_req}, 32'h0);
      check("frz_inst", id_inst, saved);
    end
    cpu_en = 1'b1;
    cycle();
    check("unfrz_req", {31'b0, last_req}, 32'h1);
    cycle();

    // Reset while waiting; the stale response arrives after release and is ignored.
    if_pc = 32'h84; next_lat = 2; next_rdata = 32'hBAD0_BAD0;
    cycle();
    rst = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    cycle();
    rst = 1'b1; cpu_en = 1'b0;
    cycle();
    check("stale_valid", {31'b0, id_valid}, 32'h0);
    check("stale_inst", id_inst, NOP);
    cpu_en = 1'b1;

    // Five fetches with 3-cycle memory: two stalled WAIT cycles each.
    next_lat = 3;
`ifdef IF_PERF_CNT_EN
    perf_base = fetch_stall_cycles;
`endif
    for (int i = 0; i < 5; i++) begin
      if_pc = 32'h100 + 32'(i * 4); next_rdata = $urandom;
      repeat (4) cycle();
    end
    check("lat3_pc", id_pc, 32'h110);
`ifdef IF_PERF_CNT_EN
    check("perf_delta", fetch_stall_cycles - perf_base, 32'd10);
`endif

    // Randomized traffic.
    spurious_en = 1;
    for (int i = 0; i < 800; i++) begin
      rst = ($urandom_range(0, 99) != 0);
      cpu_en = ($urandom_range(0, 9) != 0);
      id_shouldStall = ($urandom_range(0, 9) < 3);
      id_shouldJumpOrBranch = ($urandom_range(0, 9) == 0);
      if_pc = {$urandom_range(0, 32'hFFFF), 2'b00};
      next_lat = $urandom_range(1, 3);
      next_rdata = $urandom;
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
